// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared encodings, FSM states and log formatting for the data memory
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } dm_state_t;

`ifndef SYNTHESIS
    // Store log line: pc, word-aligned address, merged word
    function automatic string log_line(input logic [31:0] pc,
                                       input logic [31:0] addr,
                                       input logic [31:0] data);
        return $sformatf("@%h: *%h <= %h", pc, addr, data);
    endfunction
`endif

endpackage

// File: rtl/dm_lane_unit.sv
// rtl/dm_lane_unit.sv - byte-lane steering, store merge, load extension, alignment check
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [3:0]  byte_en,
    output logic [31:0] merged,
    output logic [31:0] load_data,
    output logic        align_err
);

    logic [31:0] lane_src;
    logic [31:0] shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane selection, alignment check and load extension from the addressed word
    always_comb begin
        byte_en   = 4'b0000;
        lane_src  = 32'h0;
        load_data = 32'h0;
        align_err = 1'b0;
        shifted   = old_word >> {addr_lo, 3'b000};
        sel_byte  = shifted[7:0];
        sel_half  = addr_lo[1] ? old_word[31:16] : old_word[15:0];
        case (size)
            SZ_BYTE: begin
                byte_en   = 4'b0001 << addr_lo;
                lane_src  = {4{wdata[7:0]}};
                load_data = {{24{sign & sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_src  = {2{wdata[15:0]}};
                load_data = {{16{sign & sel_half[15]}}, sel_half};
                align_err = addr_lo[0];
            end
            SZ_WORD: begin
                byte_en   = 4'b1111;
                lane_src  = wdata;
                load_data = old_word;
                align_err = (addr_lo != 2'b00);
            end
            default: begin
                align_err = 1'b1;
            end
        endcase
    end

    // Merge replicated store data into the old word under the byte enables
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = lane_src[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_subword_mem.sv
// rtl/dm_subword_mem.sv - data memory with sub-word access, clear sweep and error reporting
module dm_subword_mem
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter bit          LOG_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int               IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [29:0]      DEPTH_30 = 30'(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    dm_state_t        state, state_next;
    logic [IDX_W-1:0] clr_cnt;

    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word;
    logic             accept;
    logic             err;

    logic [3:0]       byte_en;
    logic [31:0]      merged;
    logic [31:0]      load_data;
    logic             align_err;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;

    assign offset    = req_addr - BASE_ADDR;
    assign in_range  = (req_addr >= BASE_ADDR) && (offset[31:2] < DEPTH_30);
    assign idx       = offset[IDX_W+1:2];
    assign rd_word   = in_range ? mem[idx] : 32'h0;
    assign req_ready = (state == ST_RUN);
    assign accept    = req_valid & req_ready;
    assign err       = align_err | ~in_range;

    dm_lane_unit u_lane (
        .addr_lo   (offset[1:0]),
        .size      (req_size),
        .sign      (req_sign),
        .wdata     (req_wdata),
        .old_word  (rd_word),
        .byte_en   (byte_en),
        .merged    (merged),
        .load_data (load_data),
        .align_err (align_err)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Leave the sweep once the last word has been zeroed
    always_comb begin
        state_next = state;
        if (state == ST_CLEAR && clr_cnt == LAST_IDX) begin
            state_next = ST_RUN;
        end
    end

    // Clear-sweep counter restarts from word 0 on every reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Single write port shared by the sweep and committed stores
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = clr_cnt;
        wr_data = 32'h0;
        if (state == ST_CLEAR) begin
            wr_en = 1'b1;
        end else if (accept && req_we && !err && (|byte_en)) begin
            wr_en   = 1'b1;
            wr_idx  = idx;
            wr_data = merged;
        end
    end

    // Memory array; no reset, the sweep zeroes it instead
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // One-cycle registered response for every accepted request
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept & err;
            rsp_rdata <= (accept && !req_we && !err) ? load_data : 32'h0;
        end
    end

`ifndef SYNTHESIS
    // Store trace of every committed write
    always @(posedge clk) begin
        if (LOG_EN && reset_n && accept && req_we && !err) begin
            $write("%s\n", log_line(req_pc, {req_addr[31:2], 2'b00}, merged));
        end
    end
`endif

endmodule

// File: tb/tb_dm_subword_mem.sv
// tb/tb_dm_subword_mem.sv - self-checking bench for dm_subword_mem
module tb_dm_subword_mem;

    localparam int DEPTH = 16;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] req_pc = 32'h0000_3000;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [BYTES];

    always #5 clk = ~clk;

    dm_subword_mem #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0),
        .LOG_EN      (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
        int unsigned n;
        if (sz == 2'b11) return 1'b1;
        n = 1 << sz;
        if ((a % n) != 0) return 1'b1;
        return (a >= BYTES);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit sgn);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_m[a + i]) << (8 * i));
        if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n;
        n = 1 << sz;
        for (int i = 0; i < n; i++) mem_m[a + i] = wd[8*i +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < BYTES; i++) mem_m[i] = 8'h00;
    endtask

    // Called at posedge+1; performs one accepted request and checks its response
    task automatic do_req(input bit we, input logic [1:0] sz, input bit sgn,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        bit e;
        logic [31:0] exp;
        e = model_err(a, sz);
        exp = (e || we) ? 32'h0 : model_load(a, sz, sgn);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_sign  = sgn;
        req_addr  = a;
        req_wdata = wd;
        req_pc    = req_pc + 32'd4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".err"}, 32'(rsp_err), 32'(e));
        check({tag, ".rdata"}, rsp_rdata, exp);
        if (we && !e) model_store(a, sz, wd);
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [1:0] sz;
        logic [31:0] a;

        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset.ready", 32'(req_ready), 32'd0);
        check("reset.valid", 32'(rsp_valid), 32'd0);
        check("reset.rdata", rsp_rdata, 32'h0);
        check("reset.err", 32'(rsp_err), 32'd0);

        // Reset pulse mid-sweep restarts the count
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midclear.ready", 32'(req_ready), 32'd0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_ready(cyc);
        check("clear.latency", 32'(cyc), 32'(DEPTH));

        for (int w = 0; w < DEPTH; w++) do_req(1'b0, 2'b10, 1'b0, 32'(w * 4), 32'h0, "clear.lw");

        // Sub-word stores and loads
        do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344, "sw8");
        do_req(1'b1, 2'b00, 1'b0, 32'hA, 32'h0000_00AB, "sbA");
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, "lw8");
        check("lw8.literal", rsp_rdata, 32'h11AB_3344);
        do_req(1'b0, 2'b00, 1'b1, 32'hA, 32'h0, "lbA");
        check("lbA.literal", rsp_rdata, 32'hFFFF_FFAB);
        do_req(1'b0, 2'b00, 1'b0, 32'hA, 32'h0, "lbuA");
        check("lbuA.literal", rsp_rdata, 32'h0000_00AB);
        do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234_8001, "sh6");
        do_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, "lh6");
        check("lh6.literal", rsp_rdata, 32'hFFFF_8001);
        do_req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, "lhu6");
        check("lhu6.literal", rsp_rdata, 32'h0000_8001);
        do_req(1'b0, 2'b10, 1'b1, 32'h4, 32'h0, "lw4");
        check("lw4.literal", rsp_rdata, 32'h8001_0000);

        // Error cases leave memory untouched
        do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, "err.lw2");
        do_req(1'b1, 2'b01, 1'b0, 32'h3, 32'hFFFF_FFFF, "err.sh3");
        do_req(1'b1, 2'b11, 1'b0, 32'h8, 32'hFFFF_FFFF, "err.rsvd");
        do_req(1'b1, 2'b10, 1'b0, 32'(BYTES), 32'hFFFF_FFFF, "err.range");
        do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, "err.high");
        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, "post.lw0");
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, "post.lw8");
        check("post.lw8.literal", rsp_rdata, 32'h11AB_3344);
        do_req(1'b0, 2'b10, 1'b0, 32'(BYTES - 4), 32'h0, "post.lwlast");

        // Back-to-back store then load
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check("b2b.v1", 32'(rsp_valid), 32'd1);
        check("b2b.r1", rsp_rdata, 32'h0);
        model_store(32'h10, 2'b10, 32'hDEAD_BEEF);
        req_we = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("b2b.v2", 32'(rsp_valid), 32'd1);
        check("b2b.r2", rsp_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        check("b2b.idle", 32'(rsp_valid), 32'd0);

        // Randomized traffic against the byte-array model
        for (int k = 0; k < 300; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, BYTES + 7));
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, "rand");
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
                check("rand.idle", 32'(rsp_valid), 32'd0);
            end
        end

        // Reset while a response is pending
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, "pre.sw");
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst.valid", 32'(rsp_valid), 32'd0);
        check("rst.ready", 32'(req_ready), 32'd0);
        reset_n = 1'b1;
        model_clear();
        wait_ready(cyc);
        check("rst.latency", 32'(cyc), 32'(DEPTH));
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "rst.lw20");
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "rst.lw10");
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, "rst.lw8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_subword_mem.md
Name: dm_subword_mem

Overview:
- Next-generation data memory for the single-cycle/pipelined MIPS core; replaces the fixed word-only DM.
- Parametrised depth; byte/half/word loads and stores with sign/zero extension.
- Valid/ready request channel; one-cycle registered response.
- Hardware zero-clear sweep after reset; alignment/range error reporting; MARS-style write log.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words; word index = addr[IDX_W+1:2].
- IDX_W, $clog2(DEPTH_WORDS), word-index width (derived, not overridden).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; requests below BASE_ADDR or beyond the last word are out of range.
- LOG_EN, 1, when 1, every committed store prints "@%h: *%h <= %h" (pc, word-aligned address, merged 32-bit word).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half is used for sub-word stores
- req_pc  in  32  PC of the instruction, used only for the log
- rsp_valid  out  1  one-cycle pulse per accepted request
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, out of range, or reserved size

Behaviour:
- One clock, synchronous active-low reset. Nothing happens on the reset_n edge itself; everything is sampled at posedge clk.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. FSM=CLEAR, clear counter=0.
- CLEAR state:
  - Each cycle with reset_n=1: mem[cnt]<=0, cnt++.
  - When cnt==DEPTH_WORDS-1 is written, go to RUN.
  - First cycle with req_ready=1 is exactly DEPTH_WORDS cycles after reset_n rises.
  - req_ready=0 throughout CLEAR.
- RUN state:
  - req_ready=1 constantly.
  - Accept = req_valid & req_ready.
  - No response backpressure; rsp_valid is high exactly one cycle after each accept, low otherwise.
  - Back-to-back accepts give back-to-back responses.
- Error check (combinational on the request):
  - err when size==11.
  - err when size==01 and addr[0]=1.
  - err when size==10 and addr[1:0]!=0.
  - err when the address is out of range.
  - On err: no memory write, no log, rsp_err=1, rsp_rdata=0.
- Store:
  - Byte: lane addr[1:0] gets wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0]; addr[1]=1 selects the upper half.
  - Word: the full word is written.
  - Unselected lanes keep their old value (read-modify-write inside the same edge via byte enables).
  - The log prints the merged word.
  - Store response: rsp_rdata=0, rsp_err=0.
- Load:
  - The word is read at the accept edge; lane extraction uses the same lane rules as stores.
  - Extension to 32 bits follows req_sign; word loads ignore req_sign.
- Ordering: a load accepted the cycle after a store to the same word returns the post-store data. There is no same-cycle hazard, since one request is accepted per cycle.
- Reset mid-operation:
  - reset_n=0 in RUN returns to CLEAR and drops the pending response (rsp_valid=0 next cycle).
  - The memory is fully re-zeroed by the sweep.
  - reset_n=0 mid-CLEAR restarts the counter at 0.
- Request inputs are ignored whenever req_ready=0.

Decomposition:
- Package dm_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - FSM enum {ST_CLEAR, ST_RUN};
  - the log format string.
- One natural sub-module, dm_lane_unit (combinational), which computes:
  - byte enables and the merged store word from addr[1:0]/size/wdata/old word;
  - the extended load data from the read word;
  - the alignment-error flag.
- The top level keeps the array, FSM, clear counter, range check and response registers.

Test Plan:
- Clear sweep: DEPTH_WORDS=16, reset_n low 3 cycles then high -> req_ready rises exactly 16 cycles later; a load of every word returns 0.
- Sub-word stores:
  - Store word 0x11223344 @0x8.
  - sb 0xAB @0xA -> log "*00000008 <= 11ab3344".
  - lb signed @0xA -> 0xFFFFFFAB.
  - lbu @0xA -> 0x000000AB.
- Halves:
  - sh 0x8001 @0x6 then lh signed @0x6 -> 0xFFFF8001.
  - lhu @0x6 -> 0x00008001.
  - lw @0x4 -> 0x80010000.
- Errors (each -> rsp_err=1, rsp_rdata=0, memory unchanged, no log line):
  - lw @0x2.
  - sh @0x3.
  - size=11.
  - sw at BASE_ADDR+4*DEPTH_WORDS.
- Back-to-back: sw 0xDEADBEEF @0x10 then lw @0x10 next cycle -> rsp_valid high two consecutive cycles; second rdata=0xDEADBEEF.
- Reset mid-run: accept a load, assert reset_n=0 the next cycle -> no rsp_valid, req_ready=0, and previously stored data reads 0 after the sweep completes.
